// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - one-at-a-time arbiter sharing unified Memory between IF and D requesters
`timescale 1ns/1ps
module mem_access_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter bit PRIORITY_RR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          grant_d;
  logic          last_grant_d;
  logic          lat_we;
  logic          pick_d;

  // On contention round-robin hands the grant to the port that did not go last.
  always_comb begin
    pick_d = d_req;
    if (d_req && if_req)
      pick_d = PRIORITY_RR ? !last_grant_d : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      grant_d      <= 1'b0;
      last_grant_d <= 1'b1;
      lat_we       <= 1'b0;
      if_ready     <= 1'b0;
      d_ready      <= 1'b0;
      if_rdata     <= '0;
      d_rdata      <= '0;
      mem_addr     <= '0;
      mem_din      <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            grant_d   <= pick_d;
            lat_we    <= pick_d && d_we;
            mem_addr  <= pick_d ? d_addr : if_addr;
            mem_din   <= pick_d ? d_wdata : '0;
            mem_read  <= !(pick_d && d_we);
            // Single-cycle accesses are already in their final cycle.
            mem_write <= pick_d && d_we && (WAIT_CYCLES == 1);
            cnt       <= CNT_INIT;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!lat_we) begin
              if (grant_d) d_rdata  <= mem_dout;
              else         if_rdata <= mem_dout;
            end
            last_grant_d <= grant_d;
            mem_addr     <= '0;
            mem_din      <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            if_ready     <= !grant_d;
            d_ready      <= grant_d;
            state        <= DONE;
          end else begin
            cnt       <= cnt - CNT_ONE;
            mem_write <= lat_we && (cnt == CNT_ONE);
          end
        end
        DONE: begin
          if_ready <= 1'b0;
          d_ready  <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - scoreboard bench for mem_access_arbiter over three parameter sets
`timescale 1ns/1ps
module tb_mem_access_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  logic        if_req [3];
  logic        d_req [3];
  logic        d_we [3];
  logic [31:0] if_addr [3];
  logic [31:0] d_addr [3];
  logic [31:0] d_wdata [3];
  logic        if_ready [3];
  logic        d_ready [3];
  logic        mem_read [3];
  logic        mem_write [3];
  logic        busy [3];
  logic [31:0] if_rdata [3];
  logic [31:0] d_rdata [3];
  logic [31:0] mem_addr [3];
  logic [31:0] mem_din [3];
  logic [31:0] mem_dout [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_d;
    bit          is_rd;
    logic [31:0] data;
  } exp_t;
  exp_t sb [$];
  logic [31:0] ref_mem [3][64];

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hA5000000 | 32'(i));
  endfunction

  // Instance 0: WAIT=2 RR; instance 1: WAIT=2 fixed D priority; instance 2: WAIT=1 RR.
  for (genvar g = 0; g < 3; g++) begin : g_i
    logic [31:0] mem [64];
    int viol = 0;
    int nwrites = 0;
    int nready = 0;

    mem_access_arbiter #(
      .WAIT_CYCLES((g == 2) ? 1 : 2),
      .PRIORITY_RR((g == 1) ? 1'b0 : 1'b1)
    ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ready(if_ready[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_ready(d_ready[g]), .d_rdata(d_rdata[g]),
      .mem_addr(mem_addr[g]), .mem_din(mem_din[g]), .mem_read(mem_read[g]),
      .mem_write(mem_write[g]), .mem_dout(mem_dout[g]), .busy(busy[g])
    );

    assign mem_dout[g] = mem[mem_addr[g][7:2]];

    always @(posedge clk) begin
      if (mem_init) begin
        for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      end else if (mem_write[g]) begin
        mem[mem_addr[g][7:2]] <= mem_din[g];
      end
    end

    always @(negedge clk) begin
      if ((if_ready[g] && d_ready[g]) || (mem_read[g] && mem_write[g])) viol = viol + 1;
      if (mem_write[g]) nwrites = nwrites + 1;
      if (if_ready[g] || d_ready[g]) nready = nready + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int wait_of(input int g);
    return (g == 2) ? 1 : 2;
  endfunction

  task automatic expect_op(input int g, input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    exp_t e;
    e.is_d  = is_d;
    e.is_rd = !we;
    e.data  = ref_mem[g][addr[7:2]];
    if (we) ref_mem[g][addr[7:2]] = wdata;
    sb.push_back(e);
  endtask

  // Wait (bounded) for a ready pulse on instance g and score it against the queue head.
  task automatic wait_grant(input int g, output int lat);
    exp_t e;
    bit   got_d;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (if_ready[g] || d_ready[g]) break;
    end
    if (!(if_ready[g] || d_ready[g])) begin
      chk("ready_timeout", 32'd0, 32'd1);
    end else if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      got_d = d_ready[g];
      chk("grant_port", 32'(got_d), 32'(e.is_d));
      if (e.is_rd) chk("rdata", got_d ? d_rdata[g] : if_rdata[g], e.data);
    end
  endtask

  task automatic single(input int g, input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat);
    expect_op(g, is_d, we, addr, wdata);
    if (is_d) begin
      d_we[g] = we; d_addr[g] = addr; d_wdata[g] = wdata; d_req[g] = 1'b1;
    end else begin
      if_addr[g] = addr; if_req[g] = 1'b1;
    end
    wait_grant(g, lat);
    chk("latency", 32'(lat), 32'(wait_of(g) + 1));
    if (is_d) d_req[g] = 1'b0;
    else if_req[g] = 1'b0;
    @(negedge clk);
    chk("ready_pulse", 32'(is_d ? d_ready[g] : if_ready[g]), 32'd0);
  endtask

  initial begin
    int lat, l1, l2, w0, r0;
    for (int g = 0; g < 3; g++) begin
      if_req[g] = 1'b0; d_req[g] = 1'b0; d_we[g] = 1'b0;
      if_addr[g] = '0; d_addr[g] = '0; d_wdata[g] = '0;
      for (int i = 0; i < 64; i++) ref_mem[g][i] = init_word(i);
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_if_ready", 32'(if_ready[0]), 32'd0);
    chk("rst_d_ready", 32'(d_ready[0]), 32'd0);
    chk("rst_mem_addr", mem_addr[0], 32'h0);
    chk("rst_mem_rw", 32'({mem_read[0], mem_write[0]}), 32'd0);
    chk("rst_rdata", if_rdata[0] | d_rdata[0], 32'h0);
    reset = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);

    single(0, 1'b0, 1'b0, 32'h10, 32'h0, lat);
    chk("t1_if_rdata", if_rdata[0], 32'hDEADBEEF);
    chk("t1_d_ready_quiet", 32'(g_i[0].nready), 32'd1);

    w0 = g_i[0].nwrites;
    single(0, 1'b1, 1'b1, 32'h20, 32'h12345678, lat);
    chk("t2_write_cycles", 32'(g_i[0].nwrites - w0), 32'd1);
    chk("t2_write_keeps_d_rdata", d_rdata[0], 32'h0);
    chk("t2_mem_word", g_i[0].mem[8], 32'h12345678);
    single(0, 1'b1, 1'b0, 32'h20, 32'h0, lat);
    chk("t2_if_rdata_kept", if_rdata[0], 32'hDEADBEEF);

    w0 = g_i[0].nwrites;
    r0 = g_i[0].nready;
    d_we[0] = 1'b1; d_addr[0] = 32'h24; d_wdata[0] = 32'hCAFEF00D; d_req[0] = 1'b1;
    @(negedge clk);
    chk("t5_in_access", 32'(busy[0]), 32'd1);
    reset = 1'b1;
    d_req[0] = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(busy[0]), 32'd0);
    chk("t5_mem_write", 32'(mem_write[0]), 32'd0);
    chk("t5_rdata_cleared", if_rdata[0] | d_rdata[0], 32'h0);
    // Both requests are raised under reset so the first RR tie follows last_grant=D.
    if_addr[0] = 32'h10; d_we[0] = 1'b0; d_addr[0] = 32'h20;
    if_req[0] = 1'b1; d_req[0] = 1'b1;
    reset = 1'b0;
    chk("t5_no_write", 32'(g_i[0].nwrites - w0), 32'd0);
    chk("t5_no_ready", 32'(g_i[0].nready - r0), 32'd0);
    chk("t5_mem_unchanged", g_i[0].mem[9], init_word(9));

    for (int k = 0; k < 4; k++) expect_op(0, k[0], 1'b0, (k[0] ? 32'h20 : 32'h10), 32'h0);
    for (int k = 0; k < 4; k++) begin
      wait_grant(0, lat);
      if (k > 0) chk("t3_spacing", 32'(lat), 32'(wait_of(0) + 2));
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    repeat (2) @(negedge clk);

    if_addr[1] = 32'h10; d_we[1] = 1'b0; d_addr[1] = 32'h20;
    for (int k = 0; k < 3; k++) expect_op(1, 1'b1, 1'b0, 32'h20, 32'h0);
    expect_op(1, 1'b0, 1'b0, 32'h10, 32'h0);
    if_req[1] = 1'b1; d_req[1] = 1'b1;
    for (int k = 0; k < 3; k++) wait_grant(1, lat);
    d_req[1] = 1'b0;
    wait_grant(1, lat);
    chk("t4_if_after_drop", 32'(lat), 32'(wait_of(1) + 2));
    if_req[1] = 1'b0;
    repeat (2) @(negedge clk);

    chk("t6_idle_addr", mem_addr[2], 32'h0);
    single(2, 1'b1, 1'b0, 32'h10, 32'h0, l1);
    single(2, 1'b0, 1'b0, 32'h14, 32'h0, l2);
    chk("t6_if_ready_edge", 32'(l1 + 1 + l2), 32'd5);
    chk("t6_idle_addr_after", mem_addr[2], 32'h0);
    chk("t6_idle_busy", 32'(busy[2]), 32'd0);

    chk("viol_inst0", 32'(g_i[0].viol), 32'd0);
    chk("viol_inst1", 32'(g_i[1].viol), 32'd0);
    chk("viol_inst2", 32'(g_i[2].viol), 32'd0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
